// File: rtl/elevator_dir_matrix_scan.sv
// elevator_dir_matrix_scan
//
// Direction display driver for a multi-car elevator dot-matrix panel. The
// matrix is scanned one column at a time, with NUM_ELV groups of COLS_PER_ELV
// columns. Each car shows one of four things: an up arrow, a down arrow, the
// arrow for its last known direction, or blank. A clock-enable divider sets
// the column dwell, so the block needs no derived clock.
//
// Car directions are sampled once per frame, when column 0 is driven. Every
// column of a car therefore draws from the same sample. When BLINK_EN is set,
// a stopped car's glyph can blink.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   elv_dir      car e direction at [2e+1:2e]: 0 down, 1 up, 2 stopped, 3 off
//   dot_col      one-hot column select, active-high
//   dot_raw      row drive, active-low (0 = LED lit)
//   frame_start  one-cycle pulse in the first cycle that column 0 is driven
module elevator_dir_matrix_scan #(
  parameter int unsigned NUM_ELV      = 2,
  parameter int unsigned COLS_PER_ELV = 5,
  parameter int unsigned ROWS         = 14,
  parameter int unsigned SCAN_DIV     = 12000,
  parameter int unsigned BLINK_EN     = 1,
  parameter int unsigned BLINK_FRAMES = 50
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [2*NUM_ELV-1:0]             elv_dir,
  output logic [NUM_ELV*COLS_PER_ELV-1:0]  dot_col,
  output logic [ROWS-1:0]                  dot_raw,
  output logic                             frame_start
);

  localparam int unsigned NumCols = NUM_ELV * COLS_PER_ELV;
  localparam int unsigned Half    = (COLS_PER_ELV - 1) / 2;
  localparam int unsigned DivW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IdxW    = (NumCols > 1) ? $clog2(NumCols) : 1;
  localparam int unsigned BlinkW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  // State
  logic [DivW-1:0]      div_cnt_q, div_cnt_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [2*NUM_ELV-1:0] dir_lat_q, dir_lat_d;
  logic [NUM_ELV-1:0]   prev_dir_q, prev_dir_d;   // 1 = up, 0 = down
  logic [BlinkW-1:0]    blink_cnt_q, blink_cnt_d;
  logic                 blink_ph_q, blink_ph_d;
  // Blink phase captured at the frame latch. The whole frame draws with it,
  // even though blink_ph may toggle on that same edge.
  logic                 frame_ph_q, frame_ph_d;
  logic [NumCols-1:0]   dot_col_q, dot_col_d;
  logic [ROWS-1:0]      dot_raw_q, dot_raw_d;
  logic                 frame_start_q, frame_start_d;

  // Combinational helpers
  logic                 tick;
  logic                 frame_latch;
  logic                 draw_ph;
  int unsigned          idx_int;
  int unsigned          cur_loc;
  int unsigned          cur_dist;
  logic [1:0]           car_code;
  logic                 car_prev;
  logic                 eff_up;
  logic                 blank;
  logic [ROWS-1:0]      glyph;
  logic [NumCols-1:0]   col_onehot;

  assign tick        = (div_cnt_q == DivW'(SCAN_DIV - 1));
  assign frame_latch = tick && (idx_q == '0);
  assign idx_int     = 32'(idx_q);

  // Divider, scan index, frame latch and blink bookkeeping
  always_comb begin
    div_cnt_d   = tick ? '0 : div_cnt_q + 1'b1;

    idx_d       = idx_q;
    if (tick) begin
      idx_d = (idx_q == IdxW'(NumCols - 1)) ? '0 : idx_q + 1'b1;
    end

    dir_lat_d   = frame_latch ? elv_dir : dir_lat_q;

    // Only codes 0 and 1 carry a real direction. Codes 2 and 3 keep history.
    prev_dir_d  = prev_dir_q;
    if (frame_latch) begin
      for (int unsigned e = 0; e < NUM_ELV; e++) begin
        if (!elv_dir[2*e+1]) begin
          prev_dir_d[e] = elv_dir[2*e];
        end
      end
    end

    blink_cnt_d = blink_cnt_q;
    blink_ph_d  = blink_ph_q;
    frame_ph_d  = frame_ph_q;
    if (frame_latch) begin
      frame_ph_d = blink_ph_q;
      if (blink_cnt_q == BlinkW'(BLINK_FRAMES - 1)) begin
        blink_cnt_d = '0;
        blink_ph_d  = ~blink_ph_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end

    frame_start_d = frame_latch;
  end

  // On the latch tick the frame phase register is not loaded yet, so use the
  // live (pre-toggle) phase there.
  assign draw_ph = frame_latch ? blink_ph_q : frame_ph_q;

  // Glyph for the column being put on the pins at this tick. It reads the
  // next-state latch and history, so column 0 already shows the new sample.
  always_comb begin
    car_code = 2'b11;
    car_prev = 1'b1;
    cur_loc  = 0;
    for (int unsigned e = 0; e < NUM_ELV; e++) begin
      if (idx_int >= e * COLS_PER_ELV && idx_int < (e + 1) * COLS_PER_ELV) begin
        car_code = dir_lat_d[2*e +: 2];
        car_prev = prev_dir_d[e];
        cur_loc  = idx_int - e * COLS_PER_ELV;
      end
    end

    cur_dist = (cur_loc >= Half) ? (cur_loc - Half) : (Half - cur_loc);
    eff_up   = car_code[1] ? car_prev : car_code[0];
    blank    = (car_code == 2'b11) ||
               ((BLINK_EN != 0) && (car_code == 2'b10) && draw_ph);

    glyph = '1;
    if (!blank) begin
      if (cur_dist == 0) begin
        glyph = '0;  // arrow shaft: whole column lit
      end else begin
        for (int unsigned r = 0; r < ROWS; r++) begin
          if (eff_up) begin
            if (r == cur_dist || r == cur_dist + 1) begin
              glyph[r] = 1'b0;
            end
          end else begin
            if (r + 1 + cur_dist == ROWS || r + 2 + cur_dist == ROWS) begin
              glyph[r] = 1'b0;
            end
          end
        end
      end
    end
  end

  always_comb begin
    col_onehot = '0;
    for (int unsigned k = 0; k < NumCols; k++) begin
      col_onehot[k] = (idx_int == k);
    end
  end

  // Outputs change only on a tick and then hold for the dwell.
  always_comb begin
    dot_col_d = tick ? col_onehot : dot_col_q;
    dot_raw_d = tick ? glyph : dot_raw_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_q     <= '0;
      idx_q         <= '0;
      dir_lat_q     <= '1;
      prev_dir_q    <= '1;
      blink_cnt_q   <= '0;
      blink_ph_q    <= 1'b0;
      frame_ph_q    <= 1'b0;
      dot_col_q     <= '0;
      dot_raw_q     <= '1;
      frame_start_q <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      idx_q         <= idx_d;
      dir_lat_q     <= dir_lat_d;
      prev_dir_q    <= prev_dir_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_ph_q    <= blink_ph_d;
      frame_ph_q    <= frame_ph_d;
      dot_col_q     <= dot_col_d;
      dot_raw_q     <= dot_raw_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign dot_col     = dot_col_q;
  assign dot_raw     = dot_raw_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_elevator_dir_matrix_scan.sv
// Testbench for elevator_dir_matrix_scan. Two instances are checked: the
// default geometry (blinking) and a 3-car / 7-column / 16-row sweep (no
// blinking). Both are checked every cycle against a frame-level model.
module tb_elevator_dir_matrix_scan;

  localparam int DIV = 4;
  localparam int NE0 = 2, C0 = 5, R0 = 14, BF0 = 3, N0 = NE0 * C0;
  localparam int NE1 = 3, C1 = 7, R1 = 16, BF1 = 2, N1 = NE1 * C1;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [3:0]     din0;
  logic [5:0]     din1;
  logic [N0-1:0]  dot_col0;
  logic [R0-1:0]  dot_raw0;
  logic           fs0;
  logic [N1-1:0]  dot_col1;
  logic [R1-1:0]  dot_raw1;
  logic           fs1;

  always #5 clk = ~clk;

  elevator_dir_matrix_scan #(
    .NUM_ELV(NE0), .COLS_PER_ELV(C0), .ROWS(R0), .SCAN_DIV(DIV),
    .BLINK_EN(1), .BLINK_FRAMES(BF0)
  ) dut0 (
    .clk(clk), .reset(rst), .elv_dir(din0),
    .dot_col(dot_col0), .dot_raw(dot_raw0), .frame_start(fs0)
  );

  elevator_dir_matrix_scan #(
    .NUM_ELV(NE1), .COLS_PER_ELV(C1), .ROWS(R1), .SCAN_DIV(DIV),
    .BLINK_EN(0), .BLINK_FRAMES(BF1)
  ) dut1 (
    .clk(clk), .reset(rst), .elv_dir(din1),
    .dot_col(dot_col1), .dot_raw(dot_raw1), .frame_start(fs1)
  );

  int          tests = 0;
  int          fails = 0;
  int          cyc;
  int          lat[2][8];
  int          prev[2][8];
  logic [31:0] exp_col[2];
  logic [31:0] exp_raw[2];
  logic        exp_fs[2];
  int          last_fs1;
  bit          first_frame = 1'b0;
  bit          after_rst2  = 1'b0;
  logic [31:0] rec0[10];
  logic [31:0] rec1;
  logic [31:0] rec_on, rec_off;
  logic [31:0] pin0[10] = '{32'h33FF, 32'h27FF, 32'h0000, 32'h27FF, 32'h33FF,
                            32'h3FF3, 32'h3FF9, 32'h0000, 32'h3FF9, 32'h3FF3};

  function automatic int ne(int u);   return (u == 0) ? NE0 : NE1; endfunction
  function automatic int cpe(int u);  return (u == 0) ? C0 : C1;   endfunction
  function automatic int rows(int u); return (u == 0) ? R0 : R1;   endfunction
  function automatic int bf(int u);   return (u == 0) ? BF0 : BF1; endfunction
  function automatic int ben(int u);  return (u == 0) ? 1 : 0;     endfunction
  function automatic int ncol(int u); return ne(u) * cpe(u);       endfunction

  function automatic int code_of(int u, int e);
    if (u == 0) return int'(din0[2*e +: 2]);
    return int'(din1[2*e +: 2]);
  endfunction

  // Picture of one column: arrow tips two rows deep, d rows from the edge.
  function automatic logic [31:0] model_glyph(int nrows, int hh, int c, int code, int pd,
                                              bit blank);
    logic [31:0] g;
    int d, dir;
    d = (c > hh) ? c - hh : hh - c;
    g = (32'h1 << nrows) - 32'h1;
    if (code == 3 || blank) return g;
    if (d == 0) return 32'h0;
    dir = (code == 2) ? pd : code;
    if (dir == 1) begin
      g[d] = 1'b0;
      g[d+1] = 1'b0;
    end else begin
      g[nrows-1-d] = 1'b0;
      g[nrows-2-d] = 1'b0;
    end
    return g;
  endfunction

  task automatic model_reset();
    cyc = 0;
    last_fs1 = -1;
    for (int u = 0; u < 2; u++) begin
      for (int e = 0; e < 8; e++) begin
        lat[u][e] = 3;
        prev[u][e] = 1;
      end
      exp_col[u] = 32'h0;
      exp_raw[u] = (32'h1 << rows(u)) - 32'h1;
      exp_fs[u] = 1'b0;
    end
  endtask

  // Advance the model by one rising edge. Frame f uses blink phase (f/BF)%2.
  task automatic model_step();
    int k, col, f, e, c;
    bit blank;
    cyc++;
    for (int u = 0; u < 2; u++) begin
      if (cyc % DIV == 0) begin
        k = cyc / DIV;
        col = (k - 1) % ncol(u);
        f = (k - 1) / ncol(u);
        if (col == 0) begin
          for (int j = 0; j < ne(u); j++) begin
            lat[u][j] = code_of(u, j);
            if (lat[u][j] < 2) prev[u][j] = lat[u][j];
          end
        end
        e = col / cpe(u);
        c = col % cpe(u);
        blank = (ben(u) == 1) && (lat[u][e] == 2) && ((f / bf(u)) % 2 == 1);
        exp_col[u] = 32'h1 << col;
        exp_raw[u] = model_glyph(rows(u), (cpe(u) - 1) / 2, c, lat[u][e], prev[u][e], blank);
        exp_fs[u] = (col == 0);
      end else begin
        exp_fs[u] = 1'b0;
      end
    end
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic compare();
    int k;
    check("dot_col0", 32'(dot_col0), exp_col[0]);
    check("dot_raw0", 32'(dot_raw0), exp_raw[0]);
    check("frame_start0", 32'(fs0), 32'(exp_fs[0]));
    check("dot_col1", 32'(dot_col1), exp_col[1]);
    check("dot_raw1", 32'(dot_raw1), exp_raw[1]);
    check("frame_start1", 32'(fs1), 32'(exp_fs[1]));
    if (fs1) begin
      if (last_fs1 >= 0) check("fs_period1", 32'(cyc - last_fs1), 32'(N1 * DIV));
      last_fs1 = cyc;
    end
    if (cyc % DIV == 0) begin
      k = cyc / DIV;
      if (first_frame && k <= 10) rec0[k-1] = 32'(dot_raw0);
      if (first_frame && k == 15) rec1 = 32'(dot_raw1);
      if (after_rst2 && k == 1) rec_on = 32'(dot_raw0);
      if (after_rst2 && k == 3 * N0 + 1) rec_off = 32'(dot_raw0);
    end
  endtask

  // Each iteration checks just after a rising edge, then may change inputs
  // on the falling edge.
  task automatic run(int n, bit rnd);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (!rst) begin
        model_step();
        compare();
      end
      @(negedge clk);
      if (rnd) begin
        if ($urandom_range(0, 15) == 0) din0 = 4'($urandom);
        if ($urandom_range(0, 15) == 0) din1 = 6'($urandom);
      end
    end
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_col0"}, 32'(dot_col0), 32'h0);
    check({tag, "_raw0"}, 32'(dot_raw0), 32'h3FFF);
    check({tag, "_fs0"}, 32'(fs0), 32'h0);
    check({tag, "_col1"}, 32'(dot_col1), 32'h0);
    check({tag, "_raw1"}, 32'(dot_raw1), 32'hFFFF);
  endtask

  initial begin
    int n;
    din0 = 4'b0100;           // car0 down, car1 up
    din1 = 6'b01_11_00;       // car0 down, car1 off, car2 up
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");

    @(negedge clk);
    rst = 1'b0;
    first_frame = 1'b1;
    run(N1 * DIV, 1'b0);
    first_frame = 1'b0;
    for (int i = 0; i < 10; i++) check("pin_first_frame0", rec0[i], pin0[i]);
    check("pin_car2_up_d3", rec1, 32'hFFE7);

    // Car0 goes stopped mid-frame: the current frame stays down, and later
    // frames show the held down arrow, blinking.
    run(50, 1'b0);
    din0 = 4'b0110;
    run(10 * N0 * DIV, 1'b0);

    run(3000, 1'b1);

    // Asynchronous reset in the middle of a scan, while column 7 is due next.
    n = 0;
    while (dot_col0 != 10'h040 && n < 200) begin
      run(1, 1'b1);
      n++;
    end
    check("reach_col6", 32'(dot_col0), 32'h40);
    run(1, 1'b0);
    rst = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    din0 = 4'b1010;           // both stopped straight after reset: up glyph
    din1 = 6'b10_11_10;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    after_rst2 = 1'b1;
    n = 0;
    while (dot_col0 == '0 && n < 20) begin
      run(1, 1'b0);
      n++;
    end
    check("first_col_latency", 32'(n), 32'(DIV));
    run(5 * N1 * DIV, 1'b0);
    after_rst2 = 1'b0;
    check("pin_stopped_up_on", rec_on, 32'h3FF3);
    check("pin_stopped_blink_off", rec_off, 32'h3FFF);

    run(1000, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
